// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional same-cycle write-to-read bypass is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int REG_ZERO   = 0;

    // Low bit index of port `port` inside a flattened bus of `width`-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits plus their registered population count.
// An issue to a register wins over a write retiring the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   iss_en,
    input  logic [ADDR_W-1:0]      iss_addr,
    input  logic                   clr0_en,
    input  logic [ADDR_W-1:0]      clr0_addr,
    input  logic                   clr1_en,
    input  logic [ADDR_W-1:0]      clr1_addr,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_next;
    logic [CW-1:0]    rise;
    logic [CW-1:0]    fall;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_en)  set_vec[iss_addr]  = 1'b1;
        if (clr0_en) clr_vec[clr0_addr] = 1'b1;
        if (clr1_en) clr_vec[clr1_addr] = 1'b1;
        set_vec[REG_ZERO] = 1'b0;
        busy_next = (busy & ~clr_vec) | set_vec;
        // Net count change: one set at most, up to two distinct clears.
        rise = '0;
        fall = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rise = rise + CW'(busy_next[i] & ~busy[i]);
            fall = fall + CW'(busy[i] & ~busy_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= busy_cnt + rise - fall;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, two write ports
// (wr1 has priority), r0 hardwired to zero. Bypass build: REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr0_live;
    logic              wr1_live;
    logic [ADDR_W-1:0] ra;

    // wr0 is dropped when wr1 targets the same register in the same cycle.
    assign wr1_live = wr1_en && (wr1_addr != ZERO_ADDR);
    assign wr0_live = wr0_en && (wr0_addr != ZERO_ADDR) &&
                      !(wr1_live && (wr1_addr == wr0_addr));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr0_live) mem[wr0_addr] <= wr0_data;
            if (wr1_live) mem[wr1_addr] <= wr1_data;
        end
    end

    // Any enabled write retires the destination, even a dropped wr0.
    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .clr0_en   (wr0_en),
        .clr0_addr (wr0_addr),
        .clr1_en   (wr1_en),
        .clr1_addr (wr1_addr),
        .busy      (busy),
        .busy_cnt  (busy_cnt)
    );

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
            if (rst && (ra != ZERO_ADDR)) begin
                rd_data[slice_lo(k, DATA_W) +: DATA_W] = mem[ra];
                rd_busy[k] = busy[ra];
`ifdef REGFILE_BYPASS_EN
                if (wr0_live && (wr0_addr == ra)) begin
                    rd_data[slice_lo(k, DATA_W) +: DATA_W] = wr0_data;
                    rd_busy[k] = iss_en && (iss_addr == ra);
                end
                if (wr1_live && (wr1_addr == ra)) begin
                    rd_data[slice_lo(k, DATA_W) +: DATA_W] = wr1_data;
                    rd_busy[k] = iss_en && (iss_addr == ra);
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp: default 32x32/2-port instance plus a
// 64-bit, 64-entry, 4-port instance.
module tb_regfile_mp;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr0_en, wr1_en, iss_en;
    logic [4:0]  wr0_addr, wr1_addr, iss_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [5:0]  busy_cnt;

    // wide instance
    logic [23:0]  w_rd_addr;
    logic [255:0] w_rd_data;
    logic [3:0]   w_rd_busy;
    logic         w_wr0_en, w_wr1_en, w_iss_en;
    logic [5:0]   w_wr0_addr, w_wr1_addr, w_iss_addr;
    logic [63:0]  w_wr0_data, w_wr1_data;
    logic [6:0]   w_busy_cnt;

    regfile_mp dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(6), .NUM_RD(4)) dut_w (
        .clk(clk), .rst(rst),
        .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
        .wr0_en(w_wr0_en), .wr0_addr(w_wr0_addr), .wr0_data(w_wr0_data),
        .wr1_en(w_wr1_en), .wr1_addr(w_wr1_addr), .wr1_data(w_wr1_data),
        .iss_en(w_iss_en), .iss_addr(w_iss_addr), .busy_cnt(w_busy_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
        logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
        logic        ie;  logic [4:0] ia;
        logic [4:0]  ra0, ra1;
        logic [31:0] d0, d1;  logic b0, b1;   // stored-contents view
        logic [31:0] yd0, yd1; logic yb0, yb1; // bypass view
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int w0e, input int w0a, input logic [31:0] w0d,
                       input int w1e, input int w1a, input logic [31:0] w1d,
                       input int ie, input int ia, input int ra0, input int ra1,
                       input logic [31:0] d0, input int b0, input logic [31:0] d1, input int b1,
                       input logic [31:0] yd0, input int yb0, input logic [31:0] yd1, input int yb1,
                       input int cnt);
        vec_t v;
        v.w0e = 1'(w0e); v.w0a = 5'(w0a); v.w0d = w0d;
        v.w1e = 1'(w1e); v.w1a = 5'(w1a); v.w1d = w1d;
        v.ie  = 1'(ie);  v.ia  = 5'(ia);
        v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
        v.d0  = d0;  v.b0  = 1'(b0);  v.d1  = d1;  v.b1  = 1'(b1);
        v.yd0 = yd0; v.yb0 = 1'(yb0); v.yd1 = yd1; v.yb1 = 1'(yb1);
        v.cnt = 6'(cnt);
        tbl.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        wr0_en = 0; wr0_addr = 0; wr0_data = 0;
        wr1_en = 0; wr1_addr = 0; wr1_data = 0;
        iss_en = 0; iss_addr = 0;
        w_wr0_en = 0; w_wr0_addr = 0; w_wr0_data = 0;
        w_wr1_en = 0; w_wr1_addr = 0; w_wr1_data = 0;
        w_iss_en = 0; w_iss_addr = 0;
    endtask

    task automatic drive(input vec_t v);
        wr0_en = v.w0e; wr0_addr = v.w0a; wr0_data = v.w0d;
        wr1_en = v.w1e; wr1_addr = v.w1a; wr1_data = v.w1d;
        iss_en = v.ie;  iss_addr = v.ia;
        rd_addr = {v.ra1, v.ra0};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rd_addr = 0;
        w_rd_addr = 0;

        // rows: wr0 | wr1 | iss | rd addrs | expected (plain) | expected (bypass) | busy_cnt
        add(1,3,'h11, 1,3,'h22, 0,0,  3,0,  0,0,0,0,          'h22,0,0,0,      0);
        add(1,0,'hFFFFFFFF, 0,0,0, 0,0, 3,0, 'h22,0,0,0,   'h22,0,0,0,      0);
        add(0,0,0, 0,0,0, 1,7,  7,3,  0,0,'h22,0,             0,0,'h22,0,      0);
        add(0,0,0, 0,0,0, 1,9,  7,9,  0,1,0,0,                0,1,0,0,         1);
        add(1,7,'h77, 0,0,0, 0,0, 7,9, 0,1,0,1,               'h77,0,0,1,      2);
        add(0,0,0, 0,0,0, 0,0,  7,9,  'h77,0,0,1,             'h77,0,0,1,      1);
        add(0,0,0, 1,4,'h55, 1,4, 4,9, 0,0,0,1,               'h55,1,0,1,      1);
        add(0,0,0, 1,4,'h66, 1,4, 4,9, 'h55,1,0,1,            'h66,1,0,1,      2);
        add(0,0,0, 0,0,0, 0,0,  4,9,  'h66,1,0,1,             'h66,1,0,1,      2);
        add(1,9,'h99, 1,4,'h44, 0,0, 4,9, 'h66,1,0,1,         'h44,0,'h99,0,   2);
        add(0,0,0, 0,0,0, 0,0,  4,9,  'h44,0,'h99,0,          'h44,0,'h99,0,   0);
        add(1,6,'hABCD, 0,0,0, 0,0, 6,0, 0,0,0,0,             'hABCD,0,0,0,    0);
        add(0,0,0, 0,0,0, 0,0,  6,3,  'hABCD,0,'h22,0,        'hABCD,0,'h22,0, 0);
        add(1,10,'hA, 1,11,'hB, 0,0, 10,11, 0,0,0,0,          'hA,0,'hB,0,     0);
        add(0,0,0, 0,0,0, 0,0,  10,11, 'hA,0,'hB,0,           'hA,0,'hB,0,     0);
        add(0,0,0, 0,0,0, 1,0,  0,1,  0,0,0,0,                0,0,0,0,         0);
        add(0,0,0, 0,0,0, 1,12, 0,12, 0,0,0,0,                0,0,0,0,         0);
        add(1,12,'h1, 1,12,'h2, 0,0, 12,11, 0,1,'hB,0,        'h2,0,'hB,0,     1);
        add(0,0,0, 0,0,0, 0,0,  12,11, 'h2,0,'hB,0,           'h2,0,'hB,0,     0);
        add(1,14,'h14, 0,0,0, 1,13, 13,14, 0,0,0,0,           0,0,'h14,0,      0);
        add(0,0,0, 0,0,0, 0,0,  13,14, 0,1,'h14,0,            0,1,'h14,0,      1);
        add(1,13,'h30, 0,0,0, 1,13, 13,14, 0,1,'h14,0,        'h30,1,'h14,0,   1);
        add(0,0,0, 0,0,0, 0,0,  13,14, 'h30,1,'h14,0,         'h30,1,'h14,0,   1);

        // ---- reset: every address reads zero / not busy ----
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_cnt", 64'(busy_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 32; a += 2) begin
            rd_addr = {5'(a + 1), 5'(a)};
            #1;
            check($sformatf("reset_rd a%0d", a), rd_data, 64'd0);
            check($sformatf("reset_busy a%0d", a), 64'(rd_busy), 64'd0);
        end
        check("reset_cnt", 64'(busy_cnt), 64'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
`ifdef REGFILE_BYPASS_EN
            check($sformatf("v%0d d0", i), 64'(rd_data[31:0]), 64'(tbl[i].yd0));
            check($sformatf("v%0d d1", i), 64'(rd_data[63:32]), 64'(tbl[i].yd1));
            check($sformatf("v%0d busy", i), 64'(rd_busy), 64'({tbl[i].yb1, tbl[i].yb0}));
`else
            check($sformatf("v%0d d0", i), 64'(rd_data[31:0]), 64'(tbl[i].d0));
            check($sformatf("v%0d d1", i), 64'(rd_data[63:32]), 64'(tbl[i].d1));
            check($sformatf("v%0d busy", i), 64'(rd_busy), 64'({tbl[i].b1, tbl[i].b0}));
`endif
            check($sformatf("v%0d cnt", i), 64'(busy_cnt), 64'(tbl[i].cnt));
        end
        @(negedge clk);
        idle();

        // ---- wide instance: four distinct reads, then fill the scoreboard ----
        w_wr0_en = 1; w_wr0_addr = 6'd1;  w_wr0_data = 64'h0123_4567_89AB_CDEF;
        w_wr1_en = 1; w_wr1_addr = 6'd2;  w_wr1_data = 64'hFEDC_BA98_7654_3210;
        @(negedge clk);
        w_wr0_addr = 6'd62; w_wr0_data = 64'hDEAD_0000_BEEF_003E;
        w_wr1_addr = 6'd63; w_wr1_data = 64'hCAFE_F00D_0000_003F;
        @(negedge clk);
        idle();
        w_rd_addr = {6'd63, 6'd62, 6'd2, 6'd1};
        #1;
        check("wide_r1",  w_rd_data[0*64 +: 64], 64'h0123_4567_89AB_CDEF);
        check("wide_r2",  w_rd_data[1*64 +: 64], 64'hFEDC_BA98_7654_3210);
        check("wide_r62", w_rd_data[2*64 +: 64], 64'hDEAD_0000_BEEF_003E);
        check("wide_r63", w_rd_data[3*64 +: 64], 64'hCAFE_F00D_0000_003F);
        for (int r = 1; r < 64; r++) begin
            @(negedge clk);
            w_iss_en = 1; w_iss_addr = 6'(r);
        end
        @(negedge clk);
        idle();
        #1;
        check("wide_cnt_full", 64'(w_busy_cnt), 64'd63);
        check("wide_busy_full", 64'(w_rd_busy), 64'hF);
        @(negedge clk);
        w_wr0_en = 1; w_wr0_addr = 6'd63; w_wr0_data = 64'd5;
        @(negedge clk);
        idle();
        #1;
        check("wide_cnt_retire", 64'(w_busy_cnt), 64'd62);
        check("wide_busy_retire", 64'(w_rd_busy), 64'h7);

        // ---- reset asserted during a write and an issue ----
        @(negedge clk);
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        iss_en = 1; iss_addr = 5'd20;
        rd_addr = {5'd3, 5'd5};
        #2;
        rst = 1'b0;
        #1;
        check("midrst_held_rd", rd_data, 64'd0);
        check("midrst_held_busy", 64'(rd_busy), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        idle();
        rst = 1'b1;
        rd_addr = {5'd20, 5'd5};
        #1;
        check("midrst_r5", 64'(rd_data[31:0]), 64'd0);
        check("midrst_busy", 64'(rd_busy), 64'd0);
        check("midrst_cnt", 64'(busy_cnt), 64'd0);
        rd_addr = {5'd4, 5'd3};
        #1;
        check("midrst_r3_r4", rd_data, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
